// File: rtl/pio_key_event_ctrl.sv
// pio_key_event_ctrl: Avalon-MM master that services a key edge-capture PIO
// and queues timestamped key events into a show-ahead FIFO.
`default_nettype none

module pio_key_event_ctrl #(
  parameter int NKEYS      = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int TS_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic [NKEYS-1:0]              mask_cfg,
  output logic [1:0]                    m_address,
  output logic                          m_chipselect,
  output logic                          m_write_n,
  output logic [31:0]                   m_writedata,
  input  logic [31:0]                   m_readdata,
  input  logic                          pio_irq,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [TS_WIDTH+NKEYS-1:0]     ev_data,
  output logic [$clog2(FIFO_DEPTH):0]   ev_level,
  output logic                          ev_overflow,
  input  logic                          ovf_clr
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int EV_W  = TS_WIDTH + NKEYS;

  localparam logic [PTR_W-1:0]    PTR_ONE = 1;
  localparam logic [LVL_W-1:0]    LVL_ONE = 1;
  localparam logic [TS_WIDTH-1:0] TS_ONE  = 1;
  localparam logic [LVL_W-1:0]    LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_INIT_MASK = 3'd0,
    S_IDLE      = 3'd1,
    S_RD_ADDR   = 3'd2,
    S_RD_DATA   = 3'd3,
    S_CLR       = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [NKEYS-1:0]     mask_shadow_q, mask_shadow_d;
  logic [NKEYS-1:0]     cap_q, cap_d;
  logic [TS_WIDTH-1:0]  ts_cap_q, ts_cap_d;
  logic [TS_WIDTH-1:0]  ts_q, ts_d;
  logic [PTR_W-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LVL_W-1:0]     count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic [EV_W-1:0]      mem_q [FIFO_DEPTH];

  logic                 bus_cs, bus_wn;
  logic [1:0]           bus_addr;
  logic [31:0]          bus_wd;
  logic                 push, pop, full, ovf_set;
  logic                 unused_rd;

  assign unused_rd = ^m_readdata;
  assign full      = (count_q == LVL_FULL);
  assign pop       = (count_q != '0) && ev_ready;
  assign ovf_set   = enable && pio_irq && full && (state_q == S_IDLE);

  always_comb begin
    state_d       = state_q;
    mask_shadow_d = mask_shadow_q;
    cap_d         = cap_q;
    ts_cap_d      = ts_cap_q;
    bus_cs        = 1'b0;
    bus_wn        = 1'b1;
    bus_addr      = 2'd0;
    bus_wd        = 32'd0;
    push          = 1'b0;
    case (state_q)
      S_INIT_MASK: begin
        bus_cs        = 1'b1;
        bus_wn        = 1'b0;
        bus_addr      = 2'd2;
        bus_wd        = 32'(mask_cfg);
        mask_shadow_d = mask_cfg;
        state_d       = S_IDLE;
      end
      S_IDLE: begin
        if (mask_cfg != mask_shadow_q)
          state_d = S_INIT_MASK;
        else if (enable && pio_irq && !full)
          state_d = S_RD_ADDR;
      end
      S_RD_ADDR: begin
        bus_cs   = 1'b1;
        bus_addr = 2'd3;
        state_d  = S_RD_DATA;
      end
      S_RD_DATA: begin
        cap_d    = m_readdata[NKEYS-1:0] & mask_shadow_q;
        ts_cap_d = ts_q;
        state_d  = S_CLR;
      end
      S_CLR: begin
        bus_cs   = 1'b1;
        bus_wn   = 1'b0;
        bus_addr = 2'd3;
        bus_wd   = 32'hFFFF_FFFF;
        push     = (cap_q != '0);
        state_d  = S_IDLE;
      end
      default: state_d = S_INIT_MASK;
    endcase
  end

  always_comb begin
    ts_d   = ts_q + TS_ONE;
    wptr_d = push ? (wptr_q + PTR_ONE) : wptr_q;
    rptr_d = pop  ? (rptr_q + PTR_ONE) : rptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + LVL_ONE;
      2'b01:   count_d = count_q - LVL_ONE;
      default: count_d = count_q;
    endcase
    ovf_d = ovf_set | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_INIT_MASK;
      mask_shadow_q <= '0;
      cap_q         <= '0;
      ts_cap_q      <= '0;
      ts_q          <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      mask_shadow_q <= mask_shadow_d;
      cap_q         <= cap_d;
      ts_cap_q      <= ts_cap_d;
      ts_q          <= ts_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      count_q       <= count_d;
      ovf_q         <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wptr_q] <= {ts_cap_q, cap_q};
  end

  // Reset state is INIT_MASK, so gate the bus with reset_n to release it immediately.
  assign m_chipselect = bus_cs & reset_n;
  assign m_write_n    = bus_wn | ~reset_n;
  assign m_address    = bus_addr & {2{reset_n}};
  assign m_writedata  = bus_wd & {32{reset_n}};

  assign ev_valid    = (count_q != '0);
  assign ev_data     = mem_q[rptr_q];
  assign ev_level    = count_q;
  assign ev_overflow = ovf_q;

endmodule

`default_nettype wire

// File: doc/pio_key_event_ctrl.md
Name: pio_key_event_ctrl

Overview:
- Autonomous Avalon-MM master controller that services the 4-key edge-capturing PIO (registers: data at address 0, irq mask at 2, edge capture at 3).
- Programs the PIO irq mask and, on PIO irq, reads the edge-capture register, then clears it.
- Queues each non-empty capture with a timestamp into an internal show-ahead FIFO drained over a valid/ready stream.
- Offloads key polling from the Nios II and sits between the PIO slave port and the CPU-side event consumer.

Parameters:
NKEYS, 4, number of key bits used from the PIO (1..32)
FIFO_DEPTH, 8, event FIFO entries; power of two, >= 2
TS_WIDTH, 16, free-running timestamp counter width

Ports:
clk  in  1  system clock
reset_n  in  1  reset
enable  in  1  allow irq servicing
mask_cfg  in  NKEYS  irq mask value to program into the PIO
m_address  out  2  PIO address
m_chipselect  out  1  PIO chipselect
m_write_n  out  1  PIO write strobe, active low
m_writedata  out  32  PIO write data
m_readdata  in  32  PIO read data; registered, valid one cycle after address
pio_irq  in  1  PIO interrupt
ev_valid  out  1  FIFO non-empty
ev_ready  in  1  consumer accepts head entry
ev_data  out  TS_WIDTH+NKEYS  {timestamp, key bitmap} at FIFO head
ev_level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy
ev_overflow  out  1  sticky: irq pending while FIFO full
ovf_clr  in  1  clears ev_overflow

Behaviour:
- Interface: reset reset_n, asynchronous, active-low; clock clk.
- Reset values:
  - Outputs: m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0, ev_valid=0, ev_level=0, ev_overflow=0.
  - Internal: FIFO empty, timestamp=0, mask_shadow=0.
  - FSM: state=INIT_MASK.
- Idle bus: chipselect=0, write_n=1, address=0, writedata=0 in every state not listed below.
- Timestamp: increments every clk and wraps modulo 2^TS_WIDTH.
- FSM states and transitions:
  - INIT_MASK: drive chipselect=1, write_n=0, address=2, writedata=zero-extended mask_cfg; mask_shadow<=mask_cfg -> IDLE.
  - IDLE, in priority order:
    - mask_cfg!=mask_shadow -> INIT_MASK.
    - Else enable && pio_irq && FIFO not full -> RD_ADDR.
    - Else stay.
  - RD_ADDR: chipselect=1, write_n=1, address=3 -> RD_DATA.
  - RD_DATA: bus idle; latch cap<=m_readdata[NKEYS-1:0] & mask_shadow; latch ts<=timestamp -> CLR.
  - CLR: chipselect=1, write_n=0, address=3, writedata=all ones -> IDLE.
    - In the same cycle, push {ts,cap} if cap!=0.
    - If cap==0 (unmasked or stale bits only), do not push; the clear still occurs.
- Service timing:
  - irq-to-clear is 3 cycles after leaving IDLE.
  - IDLE always lasts >= 1 cycle after CLR, so pio_irq reflects the cleared register before the next decision.
- Capture gap: the PIO clear overrides edges arriving in the CLR cycle, so such edges are lost. This is an accepted limitation. Edges arriving during RD_ADDR/RD_DATA are set in the register but are also cleared.
- FIFO behaviour:
  - Show-ahead: ev_data is valid whenever ev_valid=1.
  - Pop on ev_valid && ev_ready.
  - Push and pop in the same cycle leave ev_level unchanged.
  - Push never occurs while full, because entry into RD_ADDR is gated on not-full and there is at most 1 push per service.
  - Pointers wrap modulo FIFO_DEPTH.
- Full FIFO:
  - No service; the PIO keeps accumulating captures, which merge into one event later.
  - ev_overflow sets on any cycle with enable && pio_irq && full && state==IDLE.
  - If set and ovf_clr occur in the same cycle, set wins.
- enable deasserted mid-sequence: the current sequence completes through CLR; afterwards the FSM only services mask updates.
- mask_cfg change mid-sequence: handled at the next IDLE, before any further service.
- Reset asserted mid-operation:
  - Immediate return to reset values; the bus is released within the same cycle (asynchronous).
  - The PIO mask is rewritten in the first cycle after reset release.

Test Plan:
1. Reset release with mask_cfg=4'hF -> first cycle: write address 2, data 0x0000000F; then IDLE, ev_valid=0.
2. PIO irq with capture=4'b0101, timestamp at RD_DATA=0x0123 -> read addr 3, clear write addr 3 on the third cycle; ev_data={0x0123,4'b0101}, ev_level=1.
3. FIFO_DEPTH=8 filled with 8 events and ev_ready=0, then a new irq -> no bus access, ev_overflow=1. Pop 1 entry -> service resumes, ev_level returns to 8. Assert ovf_clr together with a new set condition -> ev_overflow stays 1.
4. mask_cfg=4'b0011, capture=4'b1100 -> read and clear performed, no push, ev_level unchanged.
5. Simultaneous push in CLR and pop (ev_ready=1) at ev_level=3 -> ev_level stays 3 and order is preserved. Run 20 events through FIFO_DEPTH=8 to check pointer wrap.
6. reset_n asserted during RD_DATA -> chipselect=0 within the same cycle, FIFO empty. After release, INIT_MASK write occurs and a pending irq is serviced next.
